// File: rtl/inst_decode_pipe_if.sv
// Fetch-to-execute channel of the instruction decode pipe: instruction input
// handshake, flush, and the decoded-entry output handshake.
interface inst_decode_pipe_if #(
    parameter int pXlen    = 32,
    parameter int pRegSelW = 5
);
    logic                iValid;
    logic                oReady;
    logic [31:0]         iInst;
    logic [pXlen-1:0]    iCurPc;
    logic                iFlushPipe;
    logic                oValid;
    logic                iReady;
    logic [6:0]          oOpcode;
    logic [pRegSelW-1:0] oRdAddr;
    logic [pRegSelW-1:0] oRs1Addr;
    logic [pRegSelW-1:0] oRs2Addr;
    logic [2:0]          oFunct3;
    logic [6:0]          oFunct7;
    logic [pXlen-1:0]    oImm;
    logic [pXlen-1:0]    oPc;
    logic [3:0]          oAluOp;
    logic                oLoad;
    logic                oStore;
    logic                oBranch;
    logic                oJump;
    logic                oRegWr;
    logic                oUseImm;
    logic                oUsePc;
    logic                oIllegal;

    // The decoder is the slave; fetch/execute together form the master view.
    modport slave (
        input  iValid, iInst, iCurPc, iFlushPipe, iReady,
        output oReady, oValid, oOpcode, oRdAddr, oRs1Addr, oRs2Addr, oFunct3,
               oFunct7, oImm, oPc, oAluOp, oLoad, oStore, oBranch, oJump,
               oRegWr, oUseImm, oUsePc, oIllegal
    );

    modport master (
        output iValid, iInst, iCurPc, iFlushPipe, iReady,
        input  oReady, oValid, oOpcode, oRdAddr, oRs1Addr, oRs2Addr, oFunct3,
               oFunct7, oImm, oPc, oAluOp, oLoad, oStore, oBranch, oJump,
               oRegWr, oUseImm, oUsePc, oIllegal
    );
endinterface

// File: rtl/inst_decode_pipe.sv
// RV32I decoder with valid/ready on both sides, 1 or 2 register stages,
// illegal-instruction detection and flush.
module inst_decode_pipe #(
    parameter int pXlen    = 32,
    parameter int pStages  = 2,
    parameter int pRegSelW = 5
) (
    input logic               iClk,
    input logic               iRst,
    inst_decode_pipe_if.slave bus
);

    typedef struct packed {
        logic [6:0]          opcode;
        logic [pRegSelW-1:0] rd;
        logic [pRegSelW-1:0] rs1;
        logic [pRegSelW-1:0] rs2;
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        logic [pXlen-1:0]    imm;
        logic [pXlen-1:0]    pc;
        logic [3:0]          aluOp;
        logic                load;
        logic                store;
        logic                branch;
        logic                jump;
        logic                regWr;
        logic                useImm;
        logic                usePc;
        logic                illegal;
    } decodeT;

    function automatic decodeT decode(input logic [31:0] inst, input logic [pXlen-1:0] pc);
        decodeT             d;
        logic signed [31:0] imm32;
        logic [2:0]         f3;
        logic [6:0]         f7;
        logic               ill;
        f3       = inst[14:12];
        f7       = inst[31:25];
        imm32    = '0;
        ill      = 1'b0;
        d        = '0;
        d.opcode = inst[6:0];
        d.rd     = pRegSelW'(inst[11:7]);
        d.rs1    = pRegSelW'(inst[19:15]);
        d.rs2    = pRegSelW'(inst[24:20]);
        d.funct3 = f3;
        d.funct7 = f7;
        d.pc     = pc;
        case (inst[6:0])
            7'b0000011: begin
                imm32 = {{20{inst[31]}}, inst[31:20]};
                {d.load, d.regWr, d.useImm} = 3'b111;
                ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            7'b0100011: begin
                imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                {d.store, d.useImm} = 2'b11;
                ill = (f3 > 3'b010);
            end
            7'b0110011: begin
                d.aluOp = {inst[30], f3};
                d.regWr = 1'b1;
                ill = !((f7 == 7'b0000000) ||
                        (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
            end
            7'b0010011: begin
                imm32   = {{20{inst[31]}}, inst[31:20]};
                // Only SRAI/SRLI use inst[30] as an opcode bit; for ADDI etc. it is immediate.
                d.aluOp = {(f3 == 3'b101) ? inst[30] : 1'b0, f3};
                {d.regWr, d.useImm} = 2'b11;
                ill = ((f3 == 3'b001) && (f7 != 7'b0000000)) ||
                      ((f3 == 3'b101) && (f7 != 7'b0000000) && (f7 != 7'b0100000));
            end
            7'b0110111: begin
                imm32   = {inst[31:12], 12'b0};
                d.aluOp = 4'b1111;
                {d.regWr, d.useImm} = 2'b11;
            end
            7'b0010111: begin
                imm32 = {inst[31:12], 12'b0};
                {d.regWr, d.useImm, d.usePc} = 3'b111;
            end
            7'b1101111: begin
                imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                {d.jump, d.regWr, d.usePc} = 3'b111;
            end
            7'b1100111: begin
                imm32 = {{20{inst[31]}}, inst[31:20]};
                {d.jump, d.regWr, d.usePc} = 3'b111;
                ill = (f3 != 3'b000);
            end
            7'b1100011: begin
                imm32   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                d.aluOp = {1'b0, f3};
                {d.branch, d.usePc, d.useImm} = 3'b111;
                ill = (f3 == 3'b010) || (f3 == 3'b011);
            end
            7'b0001111, 7'b1110011: ;
            default: ill = 1'b1;
        endcase
        d.imm = pXlen'(imm32);
        if (ill) begin
            {d.load, d.store, d.branch, d.jump, d.regWr, d.useImm, d.usePc} = '0;
            d.imm   = '0;
            d.aluOp = '0;
        end
        d.illegal = ill;
        return d;
    endfunction

    logic             readyEn;
    logic             lastAdv;
    logic             lastInValid;
    logic [31:0]      lastInInst;
    logic [pXlen-1:0] lastInPc;
    logic             outValid;
    decodeT           outReg;

    assign lastAdv = !outValid || bus.iReady;

    // Input is refused until the first clock edge after reset release.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) readyEn <= 1'b0;
        else       readyEn <= 1'b1;
    end

    generate
        if (pStages == 2) begin : gTwoStage
            logic             s1Valid;
            logic [31:0]      s1Inst;
            logic [pXlen-1:0] s1Pc;
            logic             s1Adv;

            assign s1Adv      = !s1Valid || lastAdv;
            assign bus.oReady = readyEn && s1Adv;

            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            always_ff @(posedge iClk or negedge iRst) begin
                if (!iRst) begin
                    s1Valid <= 1'b0;
                    s1Inst  <= '0;
                    s1Pc    <= '0;
                end else begin
                    if (bus.iFlushPipe) s1Valid <= 1'b0;
                    else if (s1Adv)     s1Valid <= bus.iValid && readyEn;
                    if (bus.iValid && bus.oReady && !bus.iFlushPipe) begin
                        s1Inst <= bus.iInst;
                        s1Pc   <= bus.iCurPc;
                    end
                end
            end

            assign lastInValid = s1Valid;
            assign lastInInst  = s1Inst;
            assign lastInPc    = s1Pc;
        end else begin : gOneStage
            assign bus.oReady  = readyEn && lastAdv;
            assign lastInValid = bus.iValid && readyEn;
            assign lastInInst  = bus.iInst;
            assign lastInPc    = bus.iCurPc;
        end
    endgenerate

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            outValid <= 1'b0;
            outReg   <= '0;
        end else begin
            if (bus.iFlushPipe) outValid <= 1'b0;
            else if (lastAdv)   outValid <= lastInValid;
            if (lastInValid && lastAdv && !bus.iFlushPipe)
                outReg <= decode(lastInInst, lastInPc);
        end
    end

    assign bus.oValid   = outValid;
    assign bus.oOpcode  = outReg.opcode;
    assign bus.oRdAddr  = outReg.rd;
    assign bus.oRs1Addr = outReg.rs1;
    assign bus.oRs2Addr = outReg.rs2;
    assign bus.oFunct3  = outReg.funct3;
    assign bus.oFunct7  = outReg.funct7;
    assign bus.oImm     = outReg.imm;
    assign bus.oPc      = outReg.pc;
    assign bus.oAluOp   = outReg.aluOp;
    // NOTE: data registers may hold stale values after a flush, so flags are gated by oValid.
    assign bus.oLoad    = outValid && outReg.load;
    assign bus.oStore   = outValid && outReg.store;
    assign bus.oBranch  = outValid && outReg.branch;
    assign bus.oJump    = outValid && outReg.jump;
    assign bus.oRegWr   = outValid && outReg.regWr;
    assign bus.oUseImm  = outValid && outReg.useImm;
    assign bus.oUsePc   = outValid && outReg.usePc;
    assign bus.oIllegal = outValid && outReg.illegal;

endmodule
